// File: rtl/hdlc_clk_pkg.sv
// Shared constants and types for the HDLC bit-clock generators (tx and rx).
package hdlc_clk_pkg;

  // Divider configuration after reset.
  localparam logic [11:0] FREQ_RST  = 12'd4;
  localparam logic [15:0] LIMIT_RST = 16'd1;

  // One bit period is 16 divider ticks; the first half drives the active level.
  localparam logic [3:0] HALF_PERIOD = 4'd8;
  localparam logic [3:0] LAST_PHASE  = 4'd15;

  // Clock-gate FSM encoding.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } tx_state_e;

  // The peer samples on rising when CPOL^CPHA=0, so we launch on the falling edge then.
  function automatic logic launch_is_rising(input logic cpol, input logic cpha);
    return cpol ^ cpha;
  endfunction

endpackage

// File: rtl/hdlc_tx_clk_gen_if.sv
// Control/status bundle between the HDLC shifter side and the tx bit-clock generator.
interface hdlc_tx_clk_gen_if;
  import hdlc_clk_pkg::*;

  // Handshake: load is a single-cycle valid with an implicit always-ready
  // receiver; baud_freq/baud_limit are sampled only in a cycle where load=1.
  // launch_en is a one-cycle strobe with no back-pressure; clk_req is a level.
  logic        en;
  logic        load;
  logic [11:0] baud_freq;
  logic [15:0] baud_limit;
  logic        sync_mode;
  logic        ext_sync_clk;
  logic        clk_req;
  logic        tx_sync_clk;
  logic        launch_en;
  logic        clk_active;
  tx_state_e   dbg_state;

  modport master (
    output en, load, baud_freq, baud_limit, sync_mode, ext_sync_clk, clk_req,
    input  tx_sync_clk, launch_en, clk_active, dbg_state
  );

  modport slave (
    input  en, load, baud_freq, baud_limit, sync_mode, ext_sync_clk, clk_req,
    output tx_sync_clk, launch_en, clk_active, dbg_state
  );

endinterface

// File: rtl/hdlc_edge_det.sv
// Three-flop synchroniser for an asynchronous clock with rising/falling edge pulses.
module hdlc_edge_det #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic pedge,
  output logic nedge
);

  logic [2:0] sync_q;

  // Shift the asynchronous input through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= {3{RST_VAL}};
    else     sync_q <= {sync_q[1:0], async_in};
  end

  assign pedge =  sync_q[1] & ~sync_q[2];
  assign nedge = ~sync_q[1] &  sync_q[2];

endmodule

// File: rtl/hdlc_tx_clk_gen.sv
// HDLC transmit bit-clock generator: fractional divider for the internal clock,
// synchronised peer clock in external mode, and a one-cycle launch strobe.
// Optional: define HDLC_TX_CLK_GATE_EN to gate the internal clock on clk_req.
module hdlc_tx_clk_gen
  import hdlc_clk_pkg::*;
#(
  parameter logic CPOL = 1'b1,
  parameter logic CPHA = 1'b1
) (
  input logic clk,
  input logic rst,
  hdlc_tx_clk_gen_if.slave bus
);

  localparam logic LAUNCH_RISE = launch_is_rising(CPOL, CPHA);

  logic        blk_rst;
  logic        hold;
  logic [11:0] freq_reg;
  logic [15:0] limit_reg;
  logic [15:0] counter;
  logic        ce_16;
  logic [3:0]  count16;
  logic        tx_q;
  logic        tx_next;
  logic        launch_pend;
  logic        launch_q;
  logic        parked;
  logic        entry_launch;
  logic        active;
  logic        ext_pedge;
  logic        ext_nedge;
  logic        ext_edge;

  // en=0 clears the datapath like reset but leaves the configuration alone.
  assign blk_rst = rst || !bus.en;
  assign hold    = blk_rst || bus.sync_mode || parked;

  // Capture a new divider configuration; zero values would stall or divide by zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      freq_reg  <= FREQ_RST;
      limit_reg <= LIMIT_RST;
    end else if (bus.load && (bus.baud_freq != '0) && (bus.baud_limit != '0)) begin
      freq_reg  <= bus.baud_freq;
      limit_reg <= bus.baud_limit;
    end
  end

  // Fractional accumulator producing the 16x tick ce_16.
  always_ff @(posedge clk) begin
    if (hold) begin
      counter <= '0;
      ce_16   <= 1'b0;
    end else if (counter >= limit_reg) begin
      counter <= counter - limit_reg;
      ce_16   <= 1'b1;
    end else begin
      counter <= counter + {4'b0, freq_reg};
      ce_16   <= 1'b0;
    end
  end

  assign tx_next = (count16 < HALF_PERIOD) ? ~CPOL : CPOL;

  // Phase counter and bit clock; launch_pend marks a tick-driven launch transition,
  // so parking or a mode switch never looks like a launch edge.
  always_ff @(posedge clk) begin
    if (hold) begin
      count16     <= '0;
      tx_q        <= CPOL;
      launch_pend <= 1'b0;
    end else if (ce_16) begin
      count16     <= count16 + 4'd1;
      tx_q        <= tx_next;
      launch_pend <= (tx_next != tx_q) && (tx_next == LAUNCH_RISE);
    end else begin
      launch_pend <= 1'b0;
    end
  end

  hdlc_edge_det #(.RST_VAL(CPOL)) u_edge_det (
    .clk      (clk),
    .rst      (blk_rst),
    .async_in (bus.ext_sync_clk),
    .pedge    (ext_pedge),
    .nedge    (ext_nedge)
  );

  assign ext_edge = LAUNCH_RISE ? ext_pedge : ext_nedge;

  // Registered launch strobe from whichever clock source is selected.
  always_ff @(posedge clk) begin
    if (blk_rst)            launch_q <= 1'b0;
    else if (bus.sync_mode) launch_q <= ext_edge;
    else                    launch_q <= launch_pend || entry_launch;
  end

`ifdef HDLC_TX_CLK_GATE_EN
  tx_state_e state;
  tx_state_e state_next;

  // Gate FSM state register.
  always_ff @(posedge clk) begin
    if (blk_rst) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Start on request; stop only on a period boundary so no bit is truncated.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (bus.clk_req && !bus.sync_mode) state_next = ST_RUN;
      ST_RUN: begin
        if (bus.sync_mode) state_next = ST_IDLE;
        else if (ce_16 && (count16 == LAST_PHASE) && !bus.clk_req) state_next = ST_IDLE;
      end
    endcase
  end

  // FSM outputs; with CPHA=0 the first bit must be presented before the first edge.
  always_comb begin
    parked       = (state == ST_IDLE);
    active       = (state == ST_RUN);
    entry_launch = (state == ST_IDLE) && bus.clk_req && !bus.sync_mode && !CPHA;
  end

  assign bus.dbg_state = state;
`else
  logic unused_clk_req;

  assign unused_clk_req = bus.clk_req;
  assign parked         = 1'b0;
  assign entry_launch   = 1'b0;
  assign active         = !blk_rst && !bus.sync_mode;
  assign bus.dbg_state  = active ? ST_RUN : ST_IDLE;
`endif

  assign bus.tx_sync_clk = tx_q;
  assign bus.launch_en   = launch_q;
  assign bus.clk_active  = active;

endmodule

// File: tb/tb_hdlc_tx_clk_gen.sv
// Directed bench for hdlc_tx_clk_gen: dut_a CPOL=1/CPHA=1, dut_b CPOL=0/CPHA=0.
module tb_hdlc_tx_clk_gen;
  import hdlc_clk_pkg::*;

`ifdef HDLC_TX_CLK_GATE_EN
  localparam int GATE_LAT = 1;
`else
  localparam int GATE_LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_q[$];
  logic prev_tx;
  int   last_fall;
  int   last_rise;
  int   width;
  int   nl;

  hdlc_tx_clk_gen_if if_a();
  hdlc_tx_clk_gen_if if_b();

  hdlc_tx_clk_gen #(.CPOL(1'b1), .CPHA(1'b1)) u_dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  hdlc_tx_clk_gen #(.CPOL(1'b0), .CPHA(1'b0)) u_dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

  // Clock and cycle stamp.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_cfg(input bit use_b, input logic [11:0] f, input logic [15:0] l);
    if (use_b) begin if_b.load = 1'b1; if_b.baud_freq = f; if_b.baud_limit = l; end
    else       begin if_a.load = 1'b1; if_a.baud_freq = f; if_a.baud_limit = l; end
    @(negedge clk);
    if_a.load = 1'b0;
    if_b.load = 1'b0;
  endtask

  // Wait (bounded) until the chosen tx clock transitions to lvl.
  task automatic wait_edge(input bit use_b, input logic lvl, input string tag);
    logic p;
    logic c;
    logic found;
    found = 1'b0;
    @(negedge clk);
    p = use_b ? if_b.tx_sync_clk : if_a.tx_sync_clk;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      c = use_b ? if_b.tx_sync_clk : if_a.tx_sync_clk;
      if (p != lvl && c == lvl) found = 1'b1;
      p = c;
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  // Watch dut_a: each falling edge queues a launch one cycle later; check period/halves.
  task automatic watch_a(input int n, input int period);
    logic tx;
    int   k;
    exp_q.delete();
    last_fall = -1;
    last_rise = -1;
    @(negedge clk);
    prev_tx = if_a.tx_sync_clk;
    @(negedge clk);
    tx = if_a.tx_sync_clk;
    if (prev_tx && !tx) exp_q.push_back(cyc + 1);
    prev_tx = tx;
    k = 0;
    while (k < n || (exp_q.size() != 0 && k < n + 4)) begin
      @(negedge clk);
      k++;
      tx = if_a.tx_sync_clk;
      if (if_a.launch_en) begin
        if (exp_q.size() == 0) chk("launch_a_unexpected", exp_q.size(), 1);
        else                   chk("launch_a_cycle", cyc, exp_q.pop_front());
      end
      if (prev_tx && !tx) begin
        exp_q.push_back(cyc + 1);
        if (last_rise >= 0) chk("high_a", cyc - last_rise, period / 2);
        if (last_fall >= 0) chk("period_a", cyc - last_fall, period);
        last_fall = cyc;
      end
      if (!prev_tx && tx) begin
        if (last_fall >= 0) chk("low_a", cyc - last_fall, period / 2);
        last_rise = cyc;
      end
      prev_tx = tx;
    end
    chk("launch_a_drain", exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    if_a.en = 1'b1; if_a.load = 1'b0; if_a.baud_freq = '0; if_a.baud_limit = '0;
    if_a.sync_mode = 1'b0; if_a.ext_sync_clk = 1'b1; if_a.clk_req = 1'b1;
    if_b.en = 1'b0; if_b.load = 1'b0; if_b.baud_freq = '0; if_b.baud_limit = '0;
    if_b.sync_mode = 1'b1; if_b.ext_sync_clk = 1'b0; if_b.clk_req = 1'b0;
    cycles(3);

    // Reset state.
    chk("rst_tx_a", 32'(if_a.tx_sync_clk), 32'd1);
    chk("rst_launch_a", 32'(if_a.launch_en), 32'd0);
    chk("rst_active_a", 32'(if_a.clk_active), 32'd0);
    chk("rst_tx_b", 32'(if_b.tx_sync_clk), 32'd0);
    rst = 1'b0;
    cycles(3);
    chk("run_active_a", 32'(if_a.clk_active), 32'd1);

    // 1: freq=1/limit=1 -> 32-cycle period, launch after each falling edge.
    load_cfg(1'b0, 12'd1, 16'd1);
    cycles(40);
    watch_a(150, 32);

    // 2: invalid loads are ignored; then freq=2/limit=1 -> 24-cycle period.
    load_cfg(1'b0, 12'd7, 16'd0);
    load_cfg(1'b0, 12'd0, 16'd9);
    cycles(5);
    watch_a(100, 32);
    load_cfg(1'b0, 12'd2, 16'd1);
    cycles(40);
    watch_a(100, 24);

    // 3: external clock on dut_b, launch 3 cycles after each ext falling edge.
    if_b.en = 1'b1;
    cycles(5);
    chk("sync_active_b", 32'(if_b.clk_active), 32'd0);
    exp_q.delete();
    for (int p = 0; p < 8; p++) begin
      if (if_b.ext_sync_clk) exp_q.push_back(cyc + 3);
      if_b.ext_sync_clk = ~if_b.ext_sync_clk;
      chk("sync_tx_b", 32'(if_b.tx_sync_clk), 32'd0);
      repeat (25) begin
        @(negedge clk);
        if (if_b.launch_en) begin
          if (exp_q.size() == 0) chk("launch_b_unexpected", exp_q.size(), 1);
          else                   chk("launch_b_cycle", cyc, exp_q.pop_front());
        end
      end
    end
    chk("launch_b_drain", exp_q.size(), 0);

    // 5: dut_b internal 1/1; en=0 mid active-high phase, then restart.
    load_cfg(1'b1, 12'd1, 16'd1);
    if_b.sync_mode = 1'b0;
    if_b.clk_req = 1'b1;
    cycles(30);
    wait_edge(1'b1, 1'b1, "wait_rise_b");
    cycles(5);
    if_b.en = 1'b0;
    cycles(1);
    chk("park_tx_b", 32'(if_b.tx_sync_clk), 32'd0);
    chk("park_launch_b", 32'(if_b.launch_en), 32'd0);
    chk("park_active_b", 32'(if_b.clk_active), 32'd0);
    nl = 0;
    repeat (20) begin
      @(negedge clk);
      if (if_b.launch_en) nl++;
    end
    chk("no_trailing_b", nl, 0);
    if_b.en = 1'b1;
    cycles(2 + GATE_LAT);
    chk("restart_pre_b", 32'(if_b.tx_sync_clk), 32'd0);
    cycles(1);
    chk("restart_rise_b", 32'(if_b.tx_sync_clk), 32'd1);
    width = 1;
    while (width < 40) begin
      @(negedge clk);
      if (!if_b.tx_sync_clk) break;
      width++;
    end
    chk("restart_high_b", width, 16);

`ifdef HDLC_TX_CLK_GATE_EN
    // 4: gated clock on dut_b (CPHA=0): pre-launch on request, stop on period end.
    if_b.clk_req = 1'b0;
    cycles(40);
    chk("gate_idle_active_b", 32'(if_b.clk_active), 32'd0);
    chk("gate_idle_tx_b", 32'(if_b.tx_sync_clk), 32'd0);
    if_b.clk_req = 1'b1;
    cycles(1);
    chk("gate_entry_launch_b", 32'(if_b.launch_en), 32'd1);
    chk("gate_entry_active_b", 32'(if_b.clk_active), 32'd1);
    cycles(1);
    chk("gate_entry_single_b", 32'(if_b.launch_en), 32'd0);
    cycles(2);
    chk("gate_first_rise_b", 32'(if_b.tx_sync_clk), 32'd1);
    cycles(6);
    if_b.clk_req = 1'b0;
    cycles(11);
    chk("gate_fall_launch_b", 32'(if_b.launch_en), 32'd1);
    chk("gate_low_tx_b", 32'(if_b.tx_sync_clk), 32'd0);
    cycles(12);
    chk("gate_hold_active_b", 32'(if_b.clk_active), 32'd1);
    cycles(1);
    chk("gate_stop_active_b", 32'(if_b.clk_active), 32'd0);
    chk("gate_stop_state_b", 32'(if_b.dbg_state), 32'(ST_IDLE));
`endif

    // 6: rst while dut_a drives its active (low) phase; config returns to 4/1.
    wait_edge(1'b0, 1'b0, "wait_fall_a");
    cycles(3);
    rst = 1'b1;
    cycles(1);
    chk("rst_run_tx_a", 32'(if_a.tx_sync_clk), 32'd1);
    chk("rst_run_launch_a", 32'(if_a.launch_en), 32'd0);
    chk("rst_run_active_a", 32'(if_a.clk_active), 32'd0);
    cycles(2);
    rst = 1'b0;
    cycles(40);
    watch_a(100, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
